icache_refill_assembler: RTL and testbench
==========================================

Name: icache_refill_assembler

Overview:
Sits between the instruction-cache miss logic and the L2 instruction channel. It accepts one line-miss request and issues a single-cycle request pulse to L2. It then collects the BEATS sequence-numbered beats of LINE_SIZE bits and presents the assembled BEATS*LINE_SIZE-bit line to the icache under a valid/ready handshake. It also handles flushes with in-flight refills and protocol errors.

Parameters:
LINE_SIZE, 128, width of one L2 beat in bits
BEATS, 4, beats per cache line; power of two; seq width = $clog2(BEATS)
ADDR_W, 26, line-address width (byte address bits above the line offset)
TIMEOUT_CYCLES, 64, watchdog limit in COLLECT (used only with the optional feature)

Ports:
clk_i  in  1  clock
rstn_i  in  1  reset; asynchronous, active-low
req_valid_i  in  1  icache miss request
req_addr_i  in  ADDR_W  line address of the miss
req_ready_o  out  1  block can accept a request (state IDLE)
flush_i  in  1  kill the current refill
l2_valid_o  out  1  request pulse to the L2 instruction channel
l2_addr_o  out  ADDR_W  request address to L2
l2_valid_i  in  1  beat valid from L2
l2_line_i  in  LINE_SIZE  beat data
l2_seq_num_i  in  $clog2(BEATS)  beat index within the line
resp_valid_o  out  1  assembled line available
resp_addr_o  out  ADDR_W  address of the assembled line
resp_line_o  out  BEATS*LINE_SIZE  line; beat k occupies bits [k*LINE_SIZE +: LINE_SIZE]
resp_ready_i  in  1  icache consumes the line
err_o  out  1  sticky protocol-error flag

Behaviour:
- Reset values: state IDLE; req_ready_o=1; l2_valid_o=0; l2_addr_o=0; resp_valid_o=0; resp_addr_o=0; resp_line_o=0; err_o=0; beat mask=0.
- State IDLE:
  - req_ready_o=1.
  - req_valid_i registers req_addr_i into addr_q, clears the mask, and moves to REQ.
  - With flush_i in the same cycle, the request is not accepted.
- State REQ (exactly 1 cycle):
  - l2_valid_o=1 and l2_addr_o=addr_q; then move to COLLECT.
  - l2_valid_o is never high for more than one consecutive cycle. L2 only starts returning beats after the request drops.
- State COLLECT:
  - l2_addr_o holds addr_q stable, because L2 resamples the address every cycle.
  - Each l2_valid_i writes l2_line_i into slot l2_seq_num_i and sets the matching mask bit.
  - Beats may arrive in any order and need not be contiguous.
  - A beat into an already-set slot overwrites the slot and sets err_o.
  - When the mask is all-ones after the update, the next state is RESP. resp_valid_o rises the cycle after the final beat is sampled.
- State RESP:
  - resp_valid_o=1; resp_addr_o and resp_line_o stay stable until resp_valid_o&&resp_ready_i, then move to IDLE.
  - Minimum request-to-request spacing is 1 (IDLE) + 1 (REQ) + BEATS + 1 (RESP) cycles.
- State DRAIN:
  - Continues counting beats without presenting a response.
  - Moves to IDLE once the mask is all-ones.
  - Exists so that late beats are never mistaken for a new refill.
- Flush:
  - In REQ or COLLECT: move to DRAIN. The REQ pulse still completes if flush_i arrives during REQ.
  - In RESP: drop resp_valid_o next cycle and go to IDLE. The flush wins over a simultaneous resp_ready_i, and the line is not consumed.
  - In IDLE or DRAIN: no effect.
- Stray beats: l2_valid_i in IDLE, REQ or RESP sets err_o and the data is discarded.
- err_o clears only on reset.
- Reset mid-operation returns all state to the reset values immediately.

Optional Feature:
REFILL_TIMEOUT_EN
- Defined:
  - A cycle counter clears on entry to COLLECT and on every accepted beat, and increments otherwise.
  - When it reaches TIMEOUT_CYCLES, set err_o, clear the mask, and re-enter REQ to reissue the same addr_q.
  - A timeout in DRAIN moves to IDLE.
- Undefined: no counter; COLLECT and DRAIN wait indefinitely.

Test Plan:
- Basic refill: req_addr_i=26'h0000123; beats seq 0..3 carry data 'hA0..'hA3 on consecutive cycles. Expect:
  - one l2_valid_o pulse with l2_addr_o=26'h0000123;
  - resp_valid_o one cycle after beat 3, with resp_line_o={A3,A2,A1,A0} and resp_addr_o=26'h0000123;
  - err_o=0.
- Out of order: beats arrive in seq order 2,0,3,1 with data D2,D0,D3,D1 -> resp_line_o={D3,D2,D1,D0}.
- Backpressure: resp_ready_i=0 for 5 cycles -> resp_valid_o and resp_line_o stable for all 5; req_ready_o=0 throughout; IDLE the cycle after ready rises.
- Flush mid-collect: flush_i after 2 beats -> the remaining 2 beats are absorbed in DRAIN; resp_valid_o never rises; req_ready_o=1 after the 4th beat; a new request is then served correctly.
- Errors: a stray beat in IDLE, and a duplicate seq 1 in COLLECT -> err_o=1 and stays 1 until rstn_i; the duplicate's data is the one that appears in resp_line_o.
- With REFILL_TIMEOUT_EN, TIMEOUT_CYCLES=8: send 1 beat then stall 8 cycles -> err_o=1 and a second l2_valid_o pulse for the same address; a full 4-beat set then produces a normal response.

Source files
------------

// File: rtl/icache_refill_assembler.sv
// Icache line refill: one L2 request pulse, out-of-order beat collection, line handshake.
// Optional watchdog with reissue on stalled refills: define REFILL_TIMEOUT_EN.
module icache_refill_assembler #(
  parameter int LINE_SIZE      = 128,
  parameter int BEATS          = 4,
  parameter int ADDR_W         = 26,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                       clk_i,
  input  logic                       rstn_i,
  input  logic                       req_valid_i,
  input  logic [ADDR_W-1:0]          req_addr_i,
  output logic                       req_ready_o,
  input  logic                       flush_i,
  output logic                       l2_valid_o,
  output logic [ADDR_W-1:0]          l2_addr_o,
  input  logic                       l2_valid_i,
  input  logic [LINE_SIZE-1:0]       l2_line_i,
  input  logic [$clog2(BEATS)-1:0]   l2_seq_num_i,
  output logic                       resp_valid_o,
  output logic [ADDR_W-1:0]          resp_addr_o,
  output logic [BEATS*LINE_SIZE-1:0] resp_line_o,
  input  logic                       resp_ready_i,
  output logic                       err_o
);

  localparam int LW = BEATS * LINE_SIZE;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_COLLECT,
    S_RESP,
    S_DRAIN
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [BEATS-1:0]  mask_q, mask_d;
  logic [LW-1:0]     line_q, line_d;
  logic              err_q, err_d;

  logic [BEATS-1:0]  mask_upd;
  logic              slot_hit;
  logic              done;
  logic              timeout;

  assign mask_upd = mask_q | (BEATS'(1) << l2_seq_num_i);
  assign slot_hit = mask_q[l2_seq_num_i];
  assign done     = l2_valid_i && (&mask_upd);

`ifdef REFILL_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          waiting;

  assign waiting = (state_q == S_COLLECT) || (state_q == S_DRAIN);
  assign timeout = waiting && !l2_valid_i &&
                   (cnt_q == CW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (!waiting || l2_valid_i) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  logic unused_cfg;

  assign timeout    = 1'b0;
  assign unused_cfg = |TIMEOUT_CYCLES;
`endif

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    mask_d  = mask_q;
    line_d  = line_q;
    err_d   = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (l2_valid_i) begin
          err_d = 1'b1;
        end
        if (req_valid_i && !flush_i) begin
          addr_d  = req_addr_i;
          mask_d  = '0;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (l2_valid_i) begin
          err_d = 1'b1;
        end
        state_d = flush_i ? S_DRAIN : S_COLLECT;
      end
      S_COLLECT: begin
        if (l2_valid_i) begin
          line_d[l2_seq_num_i*LINE_SIZE +: LINE_SIZE] = l2_line_i;
          mask_d = mask_upd;
          if (slot_hit) begin
            err_d = 1'b1;
          end
        end
        // A flush that lands on the final beat has nothing left to drain.
        if (flush_i) begin
          state_d = done ? S_IDLE : S_DRAIN;
        end else if (done) begin
          state_d = S_RESP;
        end else if (timeout) begin
          err_d   = 1'b1;
          mask_d  = '0;
          state_d = S_REQ;
        end
      end
      S_RESP: begin
        if (l2_valid_i) begin
          err_d = 1'b1;
        end
        if (flush_i || resp_ready_i) begin
          state_d = S_IDLE;
        end
      end
      S_DRAIN: begin
        if (l2_valid_i) begin
          mask_d = mask_upd;
          if (slot_hit) begin
            err_d = 1'b1;
          end
        end
        if (done || timeout) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      mask_q  <= '0;
      line_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      mask_q  <= mask_d;
      line_q  <= line_d;
      err_q   <= err_d;
    end
  end

  assign req_ready_o  = (state_q == S_IDLE);
  assign l2_valid_o   = (state_q == S_REQ);
  assign l2_addr_o    = addr_q;
  assign resp_valid_o = (state_q == S_RESP);
  assign resp_addr_o  = addr_q;
  assign resp_line_o  = line_q;
  assign err_o        = err_q;

endmodule

// File: tb/tb_icache_refill_assembler.sv
// Randomized bench for icache_refill_assembler against a slot-array line model.
// Timeout scenario runs only when REFILL_TIMEOUT_EN is defined.
module tb_icache_refill_assembler;

  localparam int LS = 128;
  localparam int NB = 4;
  localparam int AW = 26;
  localparam int SW = $clog2(NB);
  localparam int LW = NB * LS;
`ifdef REFILL_TIMEOUT_EN
  localparam int TO = 8;
`else
  localparam int TO = 64;
`endif

  logic          clk;
  logic          rstn;
  logic          req_valid;
  logic [AW-1:0] req_addr;
  logic          req_ready;
  logic          flush;
  logic          l2_valid_o;
  logic [AW-1:0] l2_addr;
  logic          l2_valid_i;
  logic [LS-1:0] l2_line;
  logic [SW-1:0] l2_seq;
  logic          resp_valid;
  logic [AW-1:0] resp_addr;
  logic [LW-1:0] resp_line;
  logic          resp_ready;
  logic          err;

  icache_refill_assembler #(
    .LINE_SIZE     (LS),
    .BEATS         (NB),
    .ADDR_W        (AW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_i       (clk),
    .rstn_i      (rstn),
    .req_valid_i (req_valid),
    .req_addr_i  (req_addr),
    .req_ready_o (req_ready),
    .flush_i     (flush),
    .l2_valid_o  (l2_valid_o),
    .l2_addr_o   (l2_addr),
    .l2_valid_i  (l2_valid_i),
    .l2_line_i   (l2_line),
    .l2_seq_num_i(l2_seq),
    .resp_valid_o(resp_valid),
    .resp_addr_o (resp_addr),
    .resp_line_o (resp_line),
    .resp_ready_i(resp_ready),
    .err_o       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: one slot per beat, seen flags, sticky error.
  logic [LS-1:0] slot [NB];
  bit            seen [NB];
  bit            exp_err;
  int            perm [NB];

  task automatic chk(string tag, logic [LW-1:0] got,
                     logic [LW-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [LW-1:0] exp_line();
    logic [LW-1:0] r;
    r = '0;
    for (int k = 0; k < NB; k++) r[k*LS +: LS] = slot[k];
    return r;
  endfunction

  function automatic logic [LS-1:0] rnd_beat();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic shuffle();
    int j, t;
    for (int i = 0; i < NB; i++) perm[i] = i;
    for (int i = NB - 1; i > 0; i--) begin
      j = $urandom_range(0, i);
      t = perm[i];
      perm[i] = perm[j];
      perm[j] = t;
    end
  endtask

  task automatic beat(int s, logic [LS-1:0] d, bit coll);
    if (coll) begin
      if (seen[s]) exp_err = 1'b1;
      seen[s] = 1'b1;
      slot[s] = d;
    end
    l2_valid_i = 1'b1;
    l2_seq     = SW'(s);
    l2_line    = d;
    step();
    l2_valid_i = 1'b0;
  endtask

  task automatic send_req(logic [AW-1:0] a);
    chk("req_ready_idle", req_ready, 1'b1);
    req_valid = 1'b1;
    req_addr  = a;
    step();
    req_valid = 1'b0;
    for (int k = 0; k < NB; k++) seen[k] = 1'b0;
    chk("l2_pulse", l2_valid_o, 1'b1);
    chk("l2_addr", l2_addr, a);
    chk("req_ready_busy", req_ready, 1'b0);
    step();
    chk("l2_pulse_end", l2_valid_o, 1'b0);
    chk("l2_addr_hold", l2_addr, a);
  endtask

  task automatic finish_resp(logic [AW-1:0] a, int bp, bit fl);
    chk("resp_valid", resp_valid, 1'b1);
    chk("resp_line", resp_line, exp_line());
    chk("resp_addr", resp_addr, a);
    chk("err", err, exp_err);
    for (int i = 0; i < bp; i++) begin
      step();
      chk("bp_valid", resp_valid, 1'b1);
      chk("bp_line", resp_line, exp_line());
      chk("bp_req_ready", req_ready, 1'b0);
    end
    resp_ready = 1'b1;
    flush      = fl;
    step();
    resp_ready = 1'b0;
    flush      = 1'b0;
    chk("resp_drop", resp_valid, 1'b0);
    chk("back_idle", req_ready, 1'b1);
  endtask

  task automatic collect(bit gaps);
    for (int i = 0; i < NB; i++) begin
      if (gaps) repeat ($urandom_range(0, 2)) step();
      beat(perm[i], rnd_beat(), 1'b1);
      if (i < NB - 1) chk("resp_early", resp_valid, 1'b0);
    end
  endtask

  task automatic refill(logic [AW-1:0] a, bit gaps, int bp, bit fl);
    send_req(a);
    collect(gaps);
    finish_resp(a, bp, fl);
  endtask

  task automatic flush_refill(int k, bit in_req);
    logic [AW-1:0] a;
    a = AW'($urandom);
    shuffle();
    req_valid = 1'b1;
    req_addr  = a;
    step();
    req_valid = 1'b0;
    chk("fl_l2_pulse", l2_valid_o, 1'b1);
    if (in_req) begin
      flush = 1'b1;
      step();
      flush = 1'b0;
      chk("fl_req_pulse_end", l2_valid_o, 1'b0);
      k = 0;
    end else begin
      step();
      for (int i = 0; i < k; i++) beat(perm[i], rnd_beat(), 1'b0);
      flush = 1'b1;
      step();
      flush = 1'b0;
    end
    for (int i = k; i < NB; i++) begin
      beat(perm[i], rnd_beat(), 1'b0);
      chk("fl_no_resp", resp_valid, 1'b0);
      chk("fl_req_ready", req_ready, i == NB - 1);
    end
  endtask

  initial begin
    int n;
    logic [AW-1:0] a;
    rstn       = 1'b0;
    req_valid  = 1'b0;
    req_addr   = '0;
    flush      = 1'b0;
    l2_valid_i = 1'b0;
    l2_line    = '0;
    l2_seq     = '0;
    resp_ready = 1'b0;
    exp_err    = 1'b0;
    for (int k = 0; k < NB; k++) begin
      slot[k] = '0;
      seen[k] = 1'b0;
    end
    #12;
    chk("rst_req_ready", req_ready, 1'b1);
    chk("rst_l2_valid", l2_valid_o, 1'b0);
    chk("rst_l2_addr", l2_addr, '0);
    chk("rst_resp_valid", resp_valid, 1'b0);
    chk("rst_resp_addr", resp_addr, '0);
    chk("rst_resp_line", resp_line, '0);
    chk("rst_err", err, 1'b0);
    step();
    rstn = 1'b1;
    step();

    // Basic in-order refill with fixed data.
    send_req(26'h0000123);
    for (int i = 0; i < NB; i++) begin
      beat(i, LS'(8'hA0 + i), 1'b1);
      if (i < NB - 1) chk("basic_early", resp_valid, 1'b0);
    end
    finish_resp(26'h0000123, 0, 1'b0);

    // Out of order 2,0,3,1.
    perm[0] = 2; perm[1] = 0; perm[2] = 3; perm[3] = 1;
    send_req(AW'($urandom));
    collect(1'b0);
    finish_resp(l2_addr, 0, 1'b0);

    // Backpressure for 5 cycles.
    shuffle();
    refill(AW'($urandom), 1'b0, 5, 1'b0);

    // Randomized refills.
    for (int it = 0; it < 10; it++) begin
      shuffle();
      refill(AW'($urandom), 1'b1, $urandom_range(0, 3),
             1'($urandom_range(0, 1)));
    end

    // Flushes in COLLECT and in REQ, then a clean refill.
    flush_refill(2, 1'b0);
    flush_refill($urandom_range(0, NB - 1), 1'b0);
    flush_refill(0, 1'b1);
    shuffle();
    refill(AW'($urandom), 1'b1, 1, 1'b0);

    // Request together with flush in IDLE is ignored.
    req_valid = 1'b1;
    flush     = 1'b1;
    req_addr  = AW'($urandom);
    step();
    req_valid = 1'b0;
    flush     = 1'b0;
    chk("idle_flush_ready", req_ready, 1'b1);
    chk("idle_flush_l2", l2_valid_o, 1'b0);

    // Stray beat in IDLE.
    beat(1, rnd_beat(), 1'b0);
    exp_err = 1'b1;
    chk("stray_err", err, exp_err);

    // Duplicate seq 1: second copy wins.
    a = AW'($urandom);
    send_req(a);
    beat(0, rnd_beat(), 1'b1);
    beat(1, rnd_beat(), 1'b1);
    beat(1, rnd_beat(), 1'b1);
    beat(2, rnd_beat(), 1'b1);
    beat(3, rnd_beat(), 1'b1);
    finish_resp(a, 0, 1'b0);
    shuffle();
    refill(AW'($urandom), 1'b1, 0, 1'b0);
    chk("err_sticky", err, 1'b1);

    // Reset mid-refill.
    send_req(AW'($urandom));
    beat(0, rnd_beat(), 1'b0);
    rstn = 1'b0;
    #1;
    chk("mid_rst_ready", req_ready, 1'b1);
    chk("mid_rst_err", err, 1'b0);
    chk("mid_rst_addr", l2_addr, '0);
    chk("mid_rst_line", resp_line, '0);
    exp_err = 1'b0;
    step();
    rstn = 1'b1;
    step();
    shuffle();
    refill(AW'($urandom), 1'b1, 2, 1'b0);

`ifdef REFILL_TIMEOUT_EN
    // One beat then a stall: watchdog reissues the same address.
    a = AW'($urandom);
    send_req(a);
    beat(0, rnd_beat(), 1'b1);
    n = 0;
    while (n < 3 * TO) begin
      step();
      n++;
      if (l2_valid_o) break;
    end
    exp_err = 1'b1;
    chk("to_cycles", n, TO);
    chk("to_pulse", l2_valid_o, 1'b1);
    chk("to_addr", l2_addr, a);
    chk("to_err", err, exp_err);
    for (int k = 0; k < NB; k++) seen[k] = 1'b0;
    step();
    chk("to_pulse_end", l2_valid_o, 1'b0);
    shuffle();
    collect(1'b0);
    finish_resp(a, 0, 1'b0);
`else
    n = 0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
